// File: rtl/simon_game_ctrl_if.sv
// rtl/simon_game_ctrl_if.sv - sequencer <-> player-input block handshake bundle
//   seq          : latched 9-tile sequence (tile i = {seq[2i], seq[2i+1]})
//   seq_counter  : tile index the player block compares against
//   playerEN     : key capture enable
//   checkEN      : one-cycle compare strobe
//   player_input : player block reports a captured key
//   check        : player block reports the captured tile matched
interface simon_game_ctrl_if;
    logic [17:0] seq;
    logic [3:0]  seq_counter;
    logic        playerEN;
    logic        checkEN;
    logic        player_input;
    logic        check;

    modport master (
        output seq, seq_counter, playerEN, checkEN,
        input  player_input, check
    );

    modport slave (
        input  seq, seq_counter, playerEN, checkEN,
        output player_input, check
    );
endinterface

// File: rtl/simon_game_ctrl.sv
// rtl/simon_game_ctrl.sv - memory-tile game sequencer: playback, player turns, rounds
//   clk, resetn      : clock, asynchronous active-low reset
//   start            : level; begins a game in IDLE/WIN/LOSE
//   keys_n           : raw active-low keys, used only to wait for all-released
//   pbus (master)    : seq/seq_counter/playerEN/checkEN out, player_input/check in
//   show_tile/valid  : tile being lit during playback
//   round            : current round (0 in IDLE)
//   win / lose       : game outcome, held until the next start
module simon_game_ctrl #(
    parameter int unsigned SHOW_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 12500000,
    parameter int unsigned MAX_ROUND   = 9,
    parameter logic [17:0] LFSR_SEED   = 18'h2A5C3
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [3:0]                keys_n,
    simon_game_ctrl_if.master         pbus,
    output logic [1:0]                show_tile,
    output logic                      show_valid,
    output logic [3:0]                round,
    output logic                      win,
    output logic                      lose
);
    typedef enum logic [3:0] {
        S_IDLE, S_SHOW_ON, S_SHOW_OFF, S_PAUSE, S_RELEASE,
        S_WAIT_INPUT, S_CHECK, S_EVAL, S_WIN, S_LOSE
    } state_t;

    localparam int unsigned T_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int          TW    = $clog2(T_MAX) + 1;
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [3:0]    MAX_R     = 4'(MAX_ROUND);

    state_t      state;
    logic [17:0] lfsr;
    logic [TW-1:0] timer;
    logic [3:0]  last_idx;

    // Index of the final tile of the current round.
    assign last_idx = round - 4'd1;

    function automatic logic [1:0] tile_of(input logic [17:0] s, input logic [3:0] idx);
        logic [4:0] b;
        b = {idx, 1'b0};
        return {s[b], s[b + 5'd1]};
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= S_IDLE;
            lfsr             <= LFSR_SEED;
            timer            <= '0;
            pbus.seq         <= '0;
            pbus.seq_counter <= '0;
            pbus.playerEN    <= 1'b0;
            pbus.checkEN     <= 1'b0;
            show_tile        <= '0;
            show_valid       <= 1'b0;
            round            <= '0;
            win              <= 1'b0;
            lose             <= 1'b0;
        end else begin
            // Free-running so the latched sequence depends on when start arrives.
            lfsr <= {lfsr[16:0], lfsr[17] ^ lfsr[10]};

            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        pbus.seq         <= lfsr;
                        pbus.seq_counter <= '0;
                        round            <= 4'd1;
                        timer            <= '0;
                        win              <= 1'b0;
                        lose             <= 1'b0;
                        // Tile 0 comes from the value being latched this edge.
                        show_tile        <= tile_of(lfsr, 4'd0);
                        show_valid       <= 1'b1;
                        state            <= S_SHOW_ON;
                    end
                end
                S_SHOW_ON: begin
                    if (timer == SHOW_LAST) begin
                        timer      <= '0;
                        show_valid <= 1'b0;
                        state      <= S_SHOW_OFF;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                S_SHOW_OFF: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (pbus.seq_counter == last_idx) begin
                            pbus.seq_counter <= '0;
                            state            <= S_RELEASE;
                        end else begin
                            pbus.seq_counter <= pbus.seq_counter + 4'd1;
                            show_tile        <= tile_of(pbus.seq, pbus.seq_counter + 4'd1);
                            show_valid       <= 1'b1;
                            state            <= S_SHOW_ON;
                        end
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                // Dark pause between a completed round and the next playback.
                S_PAUSE: begin
                    if (timer == GAP_LAST) begin
                        timer      <= '0;
                        show_tile  <= tile_of(pbus.seq, 4'd0);
                        show_valid <= 1'b1;
                        state      <= S_SHOW_ON;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                // Holding a key through this state must not count as a new press.
                S_RELEASE: begin
                    if (keys_n == 4'hF) begin
                        pbus.playerEN <= 1'b1;
                        state         <= S_WAIT_INPUT;
                    end
                end
                S_WAIT_INPUT: begin
                    if (pbus.player_input) begin
                        pbus.playerEN <= 1'b0;
                        pbus.checkEN  <= 1'b1;
                        state         <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    pbus.checkEN <= 1'b0;
                    state        <= S_EVAL;
                end
                S_EVAL: begin
                    if (!pbus.check) begin
                        lose  <= 1'b1;
                        state <= S_LOSE;
                    end else if (pbus.seq_counter != last_idx) begin
                        pbus.seq_counter <= pbus.seq_counter + 4'd1;
                        state            <= S_RELEASE;
                    end else if (round == MAX_R) begin
                        win   <= 1'b1;
                        state <= S_WIN;
                    end else begin
                        round            <= round + 4'd1;
                        pbus.seq_counter <= '0;
                        timer            <= '0;
                        state            <= S_PAUSE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb/tb_simon_game_ctrl.sv - scoreboard bench for simon_game_ctrl
module tb_simon_game_ctrl;
    localparam int          SHOW = 4;
    localparam int          GAP  = 2;
    localparam logic [17:0] SEED = 18'h2A5C3;

    logic       clk = 1'b0;
    logic       resetn, start_r, sel, pi, ck;
    logic [3:0] keys_n;
    logic       start_a, start_b;

    always #5 clk = ~clk;

    simon_game_ctrl_if ia();
    simon_game_ctrl_if ib();
    assign ia.player_input = pi;
    assign ia.check        = ck;
    assign ib.player_input = pi;
    assign ib.check        = ck;
    assign start_a = start_r & ~sel;
    assign start_b = start_r & sel;

    logic [1:0] st_a, st_b;
    logic       sv_a, sv_b, w_a, w_b, l_a, l_b;
    logic [3:0] rd_a, rd_b;

    simon_game_ctrl #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .MAX_ROUND(9), .LFSR_SEED(SEED)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .keys_n(keys_n), .pbus(ia),
        .show_tile(st_a), .show_valid(sv_a), .round(rd_a), .win(w_a), .lose(l_a));

    simon_game_ctrl #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .MAX_ROUND(2), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .keys_n(keys_n), .pbus(ib),
        .show_tile(st_b), .show_valid(sv_b), .round(rd_b), .win(w_b), .lose(l_b));

    // Observed signals of whichever instance is under test.
    logic [17:0] seq;
    logic [3:0]  sc, round;
    logic [1:0]  show_tile;
    logic        pen, cen, show_valid, win, lose;
    assign seq        = sel ? ib.seq         : ia.seq;
    assign sc         = sel ? ib.seq_counter : ia.seq_counter;
    assign pen        = sel ? ib.playerEN    : ia.playerEN;
    assign cen        = sel ? ib.checkEN     : ia.checkEN;
    assign show_tile  = sel ? st_b : st_a;
    assign show_valid = sel ? sv_b : sv_a;
    assign round      = sel ? rd_b : rd_a;
    assign win        = sel ? w_b  : w_a;
    assign lose       = sel ? l_b  : l_a;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference sequence source: 18-bit Fibonacci LFSR, taps 18 and 11.
    logic [17:0] m_lfsr;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= SEED;
        else         m_lfsr <= {m_lfsr[16:0], m_lfsr[17] ^ m_lfsr[10]};
    end

    function automatic logic [1:0] tile(input logic [17:0] s, input int i);
        return {s[2*i], s[2*i+1]};
    endfunction

    logic [1:0]  exp_q[$];
    logic [17:0] cur_seq;

    // Playback monitor + invariants.
    int on_cnt, gap_cnt;
    bit gap_act, prev_cen;
    logic [1:0] e;
    always @(negedge clk) begin
        if (!resetn) begin
            on_cnt = 0; gap_cnt = 0; gap_act = 0; prev_cen = 0;
        end else begin
            expect_eq("excl_pen_cen", {31'd0, pen & cen}, 0);
            expect_eq("cen_twice", {31'd0, cen & prev_cen}, 0);
            expect_eq("sc_max", {31'd0, sc <= 4'd8}, 1);
            expect_eq("round_max", {31'd0, round <= (sel ? 4'd2 : 4'd9)}, 1);
            prev_cen = cen;
            if (show_valid) begin
                if (on_cnt == 0) begin
                    if (gap_act) expect_eq("gap_len", gap_cnt, GAP);
                    if (exp_q.size() == 0) expect_eq("show_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        expect_eq("show_tile", {30'd0, show_tile}, {30'd0, e});
                    end
                end
                on_cnt++;
                gap_act = 0;
            end else begin
                if (on_cnt != 0) begin
                    expect_eq("show_len", on_cnt, SHOW);
                    gap_act = 1;
                    gap_cnt = 0;
                end
                on_cnt = 0;
                if (gap_act) gap_cnt++;
                if (gap_act && pen) begin
                    // SHOW_OFF gap plus one RELEASE cycle before capture opens.
                    expect_eq("pen_after_gap", gap_cnt, GAP + 2);
                    gap_act = 0;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        expect_eq({tag, "_seq"}, {14'd0, seq}, 0);
        expect_eq({tag, "_sc"}, {28'd0, sc}, 0);
        expect_eq({tag, "_pen"}, {31'd0, pen}, 0);
        expect_eq({tag, "_cen"}, {31'd0, cen}, 0);
        expect_eq({tag, "_tile"}, {30'd0, show_tile}, 0);
        expect_eq({tag, "_sv"}, {31'd0, show_valid}, 0);
        expect_eq({tag, "_round"}, {28'd0, round}, 0);
        expect_eq({tag, "_win"}, {31'd0, win}, 0);
        expect_eq({tag, "_lose"}, {31'd0, lose}, 0);
    endtask

    task automatic do_start(input string tag);
        cur_seq = m_lfsr;
        exp_q.push_back(tile(cur_seq, 0));
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        expect_eq({tag, "_seq"}, {14'd0, seq}, {14'd0, cur_seq});
        expect_eq({tag, "_round"}, {28'd0, round}, 1);
        expect_eq({tag, "_win"}, {31'd0, win}, 0);
        expect_eq({tag, "_lose"}, {31'd0, lose}, 0);
    endtask

    task automatic wait_pen(input string tag);
        int n;
        n = 0;
        while (!pen && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pen) expect_eq({tag, "_pen_timeout"}, 0, 1);
    endtask

    task automatic push_round(input int r);
        for (int i = 0; i < r; i++) exp_q.push_back(tile(cur_seq, i));
    endtask

    task automatic press(input string tag, input bit ok, input bit hold);
        logic [3:0] s0;
        s0 = sc;
        pi = 1'b1;
        ck = ok;
        if (hold) keys_n = 4'hE;
        @(negedge clk);
        pi = 1'b0;
        expect_eq({tag, "_pen_drop"}, {31'd0, pen}, 0);
        expect_eq({tag, "_cen_pulse"}, {31'd0, cen}, 1);
        expect_eq({tag, "_sc_stable1"}, {28'd0, sc}, {28'd0, s0});
        @(negedge clk);
        expect_eq({tag, "_cen_once"}, {31'd0, cen}, 0);
        expect_eq({tag, "_sc_stable2"}, {28'd0, sc}, {28'd0, s0});
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1 check_zero(tag);
        exp_q.delete();
        @(negedge clk);
        #2 resetn = 1'b1;
        repeat (6) @(negedge clk);
        expect_eq({tag, "_stay_sv"}, {31'd0, show_valid}, 0);
        expect_eq({tag, "_stay_round"}, {28'd0, round}, 0);
        expect_eq({tag, "_stay_pen"}, {31'd0, pen}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start_r = 1'b0; sel = 1'b0; pi = 1'b0; ck = 1'b0; keys_n = 4'hF;
        repeat (3) @(negedge clk);
        check_zero("reset");
        #2 resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Round 1 on the 9-round instance.
        do_start("start1");
        wait_pen("r1");
        expect_eq("r1_sc", {28'd0, sc}, 0);
        push_round(2);
        press("r1t0", 1'b1, 1'b0);
        expect_eq("r2_round", {28'd0, round}, 2);
        expect_eq("r2_sc", {28'd0, sc}, 0);

        // Round 2: first press with a key held down.
        wait_pen("r2");
        press("r2t0", 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) expect_eq("release_hold_pen", {31'd0, pen}, 0);
        repeat (4) @(negedge clk);
        expect_eq("release_hold_pen_late", {31'd0, pen}, 0);
        keys_n = 4'hF;
        @(negedge clk);
        @(negedge clk);
        expect_eq("release_pen", {31'd0, pen}, 1);
        expect_eq("r2t1_sc", {28'd0, sc}, 1);
        push_round(3);
        press("r2t1", 1'b1, 1'b0);
        expect_eq("r3_round", {28'd0, round}, 3);

        // Round 3: miss on the second tile.
        wait_pen("r3");
        press("r3t0", 1'b1, 1'b0);
        wait_pen("r3b");
        expect_eq("r3t1_sc", {28'd0, sc}, 1);
        press("r3t1", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pi = 1'b1;
            @(negedge clk);
            expect_eq("lose_flag", {31'd0, lose}, 1);
            expect_eq("lose_pen", {31'd0, pen}, 0);
            expect_eq("lose_sc", {28'd0, sc}, 1);
            expect_eq("lose_round", {28'd0, round}, 3);
            expect_eq("lose_cen", {31'd0, cen}, 0);
        end
        pi = 1'b0;

        // Restart from LOSE, then reset during SHOW_ON.
        do_start("restart");
        expect_eq("restart_sv", {31'd0, show_valid}, 1);
        async_reset("rst_show");

        // Reset while checkEN is high.
        do_start("start2");
        wait_pen("s2");
        pi = 1'b1; ck = 1'b1;
        @(negedge clk);
        pi = 1'b0;
        expect_eq("s2_cen", {31'd0, cen}, 1);
        async_reset("rst_check");

        // Two-round instance: play to WIN.
        sel = 1'b1;
        @(negedge clk);
        do_start("b_start");
        wait_pen("b1");
        push_round(2);
        press("b1t0", 1'b1, 1'b0);
        expect_eq("b_round2", {28'd0, round}, 2);
        wait_pen("b2");
        press("b2t0", 1'b1, 1'b0);
        wait_pen("b2b");
        press("b2t1", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pi = 1'b1;
            expect_eq("win_flag", {31'd0, win}, 1);
            expect_eq("win_round", {28'd0, round}, 2);
            expect_eq("win_lose", {31'd0, lose}, 0);
            expect_eq("win_pen", {31'd0, pen}, 0);
            expect_eq("win_cen", {31'd0, cen}, 0);
            @(negedge clk);
        end
        pi = 1'b0;
        expect_eq("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
